// File: rtl/unidad_control_riesgos.sv
// unidad_control_riesgos
// Hazard-control unit for the 5-stage MIPS pipeline. It sits beside the ID
// stage and detects two kinds of hazard:
//   - load-use: the ID instruction reads the destination of a load in EX;
//   - branch-operand: a branch resolved in ID reads a register that is still
//     being produced by EX (ALU result) or by MEM (load data).
// From these it drives the PC / IF-ID stall, the ID-EX bubble and the IF-ID
// flush. Load-use stalls are stretched to LOAD_LAT cycles by a small FSM.
// Two saturating counters record bubble cycles and flushes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no stretched stall pending; stall follows the hazard inputs
// HOLD  | stretching a load-use stall; cnt = remaining stall cycles
//
// Ports:
//   i_clk, i_reset                    clock, synchronous active-high reset
//   i_rs_ID, i_rt_ID, i_uses_*_ID     ID-stage operands and their use flags
//   i_branch_ID, i_branch_taken_ID    ID-stage branch and its resolution
//   i_rt_EX, i_mem_read_EX            load in EX and its destination
//   i_write_reg_EX, i_reg_write_EX    EX destination and write enable
//   i_write_reg_MEM, i_mem_read_MEM   MEM destination and load flag
//   i_halt                            debug freeze
//   o_stall_pc, o_stall_if_id         hold PC and IF/ID
//   o_bubble_id_ex                    insert NOP into ID/EX
//   o_flush_if_id                     clear IF/ID after a taken branch
//   o_busy                            FSM is in HOLD
//   o_stall_cnt, o_flush_cnt          saturating event counters
module unidad_control_riesgos #(
    parameter int REG_W        = 5,
    parameter int LOAD_LAT     = 1,
    parameter int BRANCH_IN_ID = 1,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [REG_W-1:0] i_rs_ID,
    input  logic [REG_W-1:0] i_rt_ID,
    input  logic             i_uses_rs_ID,
    input  logic             i_uses_rt_ID,
    input  logic             i_branch_ID,
    input  logic             i_branch_taken_ID,
    input  logic [REG_W-1:0] i_rt_EX,
    input  logic             i_mem_read_EX,
    input  logic [REG_W-1:0] i_write_reg_EX,
    input  logic             i_reg_write_EX,
    input  logic [REG_W-1:0] i_write_reg_MEM,
    input  logic             i_mem_read_MEM,
    input  logic             i_halt,
    output logic             o_stall_pc,
    output logic             o_stall_if_id,
    output logic             o_bubble_id_ex,
    output logic             o_flush_if_id,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam bit             USE_HOLD  = (LOAD_LAT > 1);
    localparam bit             BR_EN     = (BRANCH_IN_ID != 0);
    localparam logic [3:0]     HOLD_INIT = 4'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       load_hz, br_hz, stall;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic match(input logic uses,
                                   input logic [REG_W-1:0] r,
                                   input logic [REG_W-1:0] t);
        return uses && (r != '0) && (r == t);
    endfunction

    always_comb begin
        load_hz = i_mem_read_EX &&
                  (match(i_uses_rs_ID, i_rs_ID, i_rt_EX) ||
                   match(i_uses_rt_ID, i_rt_ID, i_rt_EX));
        br_hz   = BR_EN && i_branch_ID &&
                  ((i_reg_write_EX &&
                    (match(i_uses_rs_ID, i_rs_ID, i_write_reg_EX) ||
                     match(i_uses_rt_ID, i_rt_ID, i_write_reg_EX))) ||
                   (i_mem_read_MEM &&
                    (match(i_uses_rs_ID, i_rs_ID, i_write_reg_MEM) ||
                     match(i_uses_rt_ID, i_rt_ID, i_write_reg_MEM))));
        stall   = (state == HOLD) || load_hz || br_hz;
    end

    // Next state. Halt freezes the FSM so a stretched stall resumes intact.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!i_halt) begin
            case (state)
                IDLE: begin
                    if (load_hz && USE_HOLD) begin
                        state_nx = HOLD;
                        cnt_nx   = HOLD_INIT;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd1) begin
                        state_nx = IDLE;
                        cnt_nx   = 4'd0;
                    end else begin
                        cnt_nx = cnt - 4'd1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end
            endcase
        end
    end

    // Outputs: reset > halt > stall > flush. A stalled branch is not flushed
    // until it resolves in an unstalled cycle.
    always_comb begin
        o_stall_pc     = 1'b0;
        o_stall_if_id  = 1'b0;
        o_bubble_id_ex = 1'b0;
        o_flush_if_id  = 1'b0;
        o_busy         = 1'b0;
        if (!i_reset) begin
            o_busy = (state == HOLD);
            if (i_halt) begin
                o_stall_pc    = 1'b1;
                o_stall_if_id = 1'b1;
            end else if (stall) begin
                o_stall_pc     = 1'b1;
                o_stall_if_id  = 1'b1;
                o_bubble_id_ex = 1'b1;
            end else begin
                o_flush_if_id = i_branch_taken_ID;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (o_bubble_id_ex && (o_stall_cnt != CNT_MAX))
                o_stall_cnt <= o_stall_cnt + CNT_ONE;
            if (o_flush_if_id && (o_flush_cnt != CNT_MAX))
                o_flush_cnt <= o_flush_cnt + CNT_ONE;
        end
    end

endmodule
